// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter FSM state encoding and the round-robin index arithmetic.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int PUSH_CNT_W = 16;

    // Requester index reached by stepping `off` places past `base`, wrapping at n.
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// (last + 1) mod N, wrapping around the request vector.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the requester
    // closest after `last` overwrites all others and wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'(wrap_add(int'(last), k, N));
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bursts of up to BURST_MAX beats with a one-beat output register.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          w_valid,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [PUSH_CNT_W-1:0]         push_cnt
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(BURST_MAX + 1);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [IDW-1:0]  last_grant_q;
    logic [BCW-1:0]  beat_cnt_q;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    logic            gnt_valid;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic            slot_free;
    logic            accept;
    logic            push;
    logic            last_beat;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_grant_q),
        .grant (pick_id),
        .any   (pick_any)
    );

    // The output register can take a new beat when empty or draining this edge.
    assign slot_free = !w_valid || !fifo_full;
    assign gnt_valid = req_valid[grant_id];
    assign accept    = (state_q == ST_GRANT) && gnt_valid && slot_free;
    assign push      = w_valid && !fifo_full;
    assign last_beat = (beat_cnt_q == BCW'(BURST_MAX - 1));
    assign busy      = (state_q == ST_GRANT) || w_valid;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                req_ready[grant_id] = slot_free;
                // A dropped valid ends the burst immediately, even if no beat was taken.
                if (!gnt_valid || (accept && last_beat)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data_in is cleared too so a reset mid-burst leaves no stale beat visible.
            w_valid      <= 1'b0;
            data_in      <= '0;
            grant_id     <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            push_cnt     <= '0;
        end else begin
            if ((state_q == ST_IDLE) && pick_any) begin
                grant_id     <= pick_id;
                last_grant_q <= pick_id;
                beat_cnt_q   <= '0;
            end else if (accept) begin
                beat_cnt_q <= beat_cnt_q + BCW'(1);
            end

            // A new accept refills the register in the same edge it drains.
            if (accept) begin
                data_in <= gnt_data;
                w_valid <= 1'b1;
            end else if (push) begin
                w_valid <= 1'b0;
            end

            if (push) begin
                push_cnt <= push_cnt + PUSH_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter driving a depth-8 FIFO model,
// with per-requester ordering scoreboard and directed plus random traffic.
module tb_fifo_wr_arbiter;

    localparam int NR      = 4;
    localparam int DW      = 32;
    localparam int BM      = 4;
    localparam int DEPTH   = 8;
    localparam int LAT_MAX = 3 * (BM + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              fifo_full = 1'b0;
    logic              w_valid;
    logic [DW-1:0]     data_in;
    logic [1:0]        grant_id;
    logic              busy;
    logic [15:0]       push_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .w_valid   (w_valid),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .push_cnt  (push_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] acc_q[$];
    int          acc_src_log[$];
    int          seq[NR];
    int          exp_pop[NR];
    int          wait_cnt[NR];
    bit          acc_last[NR];
    int          model_pushes;
    bit          pop;
    bit          lat_en;

    typedef struct {
        logic [NR-1:0] valid;
        logic [1:0]    exp_grant;
        logic [NR-1:0] exp_ready;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] make_word(input int i, input int s);
        logic [31:0] iv;
        logic [31:0] sv;
        iv = i;
        sv = s;
        return {iv[7:0], sv[23:0]};
    endfunction

    task automatic clear_model();
        fifo_q.delete();
        acc_q.delete();
        acc_src_log.delete();
        for (int i = 0; i < NR; i++) begin
            seq[i]      = 0;
            exp_pop[i]  = 0;
            wait_cnt[i] = 0;
            acc_last[i] = 1'b0;
        end
        model_pushes = 0;
        fifo_full    = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_w_valid"},   w_valid,   0);
        check({tag, "_data_in"},   data_in,   0);
        check({tag, "_grant_id"},  grant_id,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_push_cnt"},  push_cnt,  0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // One clock cycle, entered and left just after a falling edge. Inputs are
    // already set by the caller; the model predicts the coming rising edge.
    task automatic cycle();
        logic [31:0] w;
        logic [31:0] e;
        int          src;
        bit          acc;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = make_word(i, seq[i]);
        #1;
        check("push_cnt", push_cnt, 16'(model_pushes));
        check("w_valid_pending", w_valid, acc_q.size() > 0);
        check("ready_onehot", $countones(req_ready) <= 1, 1);
        if (req_ready != '0) check("ready_while_stalled", w_valid && fifo_full, 0);

        if (pop && fifo_q.size() > 0) begin
            w   = fifo_q.pop_front();
            src = int'(w[31:24]);
            if (src < NR) begin
                check("pop_order", w[23:0], 24'(exp_pop[src]));
                exp_pop[src]++;
            end else begin
                check("pop_src", src, 0);
            end
        end
        if (w_valid && !fifo_full) begin
            if (acc_q.size() == 0) begin
                check("push_without_beat", 1, 0);
            end else begin
                e = acc_q.pop_front();
                check("push_data", data_in, e);
            end
            fifo_q.push_back(data_in);
            model_pushes++;
        end
        for (int i = 0; i < NR; i++) begin
            acc = req_valid[i] && req_ready[i];
            acc_last[i] = acc;
            if (acc) begin
                acc_q.push_back(make_word(i, seq[i]));
                acc_src_log.push_back(i);
                seq[i]++;
                if (lat_en) check("latency", wait_cnt[i] <= LAT_MAX + 1, 1);
                wait_cnt[i] = 0;
            end else if (!req_valid[i]) begin
                wait_cnt[i] = 0;
            end else if (!fifo_full) begin
                wait_cnt[i]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        pop       = 1'b0;
        lat_en    = 1'b0;
        clear_model();
        #1;
        check_reset(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int pct;
        logic [31:0] held;

        vecs[0]  = '{4'b1111, 2'd0, 4'b0001};
        vecs[1]  = '{4'b1111, 2'd1, 4'b0010};
        vecs[2]  = '{4'b0001, 2'd0, 4'b0001};
        vecs[3]  = '{4'b1100, 2'd2, 4'b0100};
        vecs[4]  = '{4'b1100, 2'd3, 4'b1000};
        vecs[5]  = '{4'b0110, 2'd1, 4'b0010};
        vecs[6]  = '{4'b1001, 2'd3, 4'b1000};
        vecs[7]  = '{4'b1001, 2'd0, 4'b0001};
        vecs[8]  = '{4'b1000, 2'd3, 4'b1000};
        vecs[9]  = '{4'b0010, 2'd1, 4'b0010};
        vecs[10] = '{4'b0101, 2'd2, 4'b0100};
        vecs[11] = '{4'b0101, 2'd0, 4'b0001};

        clear_model();
        pop    = 1'b0;
        lat_en = 1'b0;

        // Round-robin pick table: one beat per grant, then drop valid.
        do_reset("rst0");
        pop = 1'b1;
        for (int v = 0; v < 12; v++) begin
            req_valid = vecs[v].valid;
            cycle();
            check($sformatf("vec%0d_grant", v), grant_id, vecs[v].exp_grant);
            check($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
            check($sformatf("vec%0d_busy", v), busy, 1);
            cycle();
            req_valid = '0;
            cycle();
            check($sformatf("vec%0d_idle", v), busy, 0);
            check($sformatf("vec%0d_hold_id", v), grant_id, vecs[v].exp_grant);
        end

        // All four requesters, eight beats each.
        do_reset("rst1");
        pop  = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            for (int i = 0; i < NR; i++) req_valid[i] = (seq[i] < 8);
            cycle();
            done = (seq[0] == 8) && (seq[1] == 8) && (seq[2] == 8) && (seq[3] == 8) && (acc_q.size() == 0);
        end
        check("s1_done", done, 1);
        check("s1_push_cnt", push_cnt, 32);
        check("s1_log_len", acc_src_log.size(), 32);
        for (int k = 0; k < acc_src_log.size() && k < 32; k++)
            check($sformatf("s1_order%0d", k), acc_src_log[k], (k / BM) % NR);
        req_valid = '0;
        repeat (10) cycle();

        // Requester 2 alone: three beats then valid drops.
        do_reset("rst2");
        pop       = 1'b1;
        req_valid = 4'b0100;
        repeat (4) cycle();
        check("s2_accepts", seq[2], 3);
        req_valid = '0;
        #1;
        check("s2_drop_busy", busy, 1);
        check("s2_drop_ready", req_ready, 4'b0100);
        cycle();
        check("s2_idle", busy, 0);
        check("s2_grant_id", grant_id, 2);
        check("s2_push_cnt", push_cnt, 3);

        // Full FIFO, no pops, requester 1 offers ten beats.
        do_reset("rst3");
        pop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (seq[1] < 10) ? 4'b0010 : 4'b0000;
            cycle();
        end
        check("s3_push_cnt", push_cnt, 8);
        check("s3_w_valid", w_valid, 1);
        check("s3_ninth", data_in, make_word(1, 8));
        check("s3_ready", req_ready, 0);
        held = data_in;
        repeat (3) cycle();
        check("s3_stable", data_in, held);
        check("s3_push_still", push_cnt, 8);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        req_valid = (seq[1] < 10) ? 4'b0010 : 4'b0000;
        cycle();
        check("s3_after_pop", push_cnt, 9);
        pop       = 1'b1;
        req_valid = '0;
        repeat (15) cycle();
        check("s3_drained", push_cnt, 10);

        // Reset mid-burst while a beat is pending.
        do_reset("rst4");
        pop       = 1'b1;
        req_valid = 4'b1111;
        done      = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            cycle();
            done = (grant_id == 2'd1) && w_valid;
        end
        check("s4_reached", done, 1);
        rst_n = 1'b0;
        #1;
        check_reset("s4_async");
        clear_model();
        @(posedge clk);
        @(negedge clk);
        check_reset("s4_held");
        rst_n = 1'b1;
        cycle();
        check("s4_first_grant", grant_id, 0);
        check("s4_busy", busy, 1);
        cycle();
        check("s4_first_src", acc_src_log.size() > 0 && acc_src_log[0] == 0, 1);

        // Random traffic with varying drain rate.
        do_reset("rst5");
        lat_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            case ((n / 500) % 3)
                0:       pct = 20;
                1:       pct = 60;
                default: pct = 100;
            endcase
            pop = ($urandom_range(0, 99) < pct);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && !acc_last[i]) req_valid[i] = 1'b1;
                else if (acc_last[i])             req_valid[i] = ($urandom_range(0, 3) != 0);
                else                              req_valid[i] = ($urandom_range(0, 2) == 0);
            end
            cycle();
        end
        for (int i = 0; i < NR; i++)
            check($sformatf("rand_wait%0d", i), wait_cnt[i] <= LAT_MAX + 1, 1);
        lat_en    = 1'b0;
        req_valid = '0;
        pop       = 1'b1;
        repeat (20) cycle();
        check("rand_idle_busy", busy, 0);
        check("rand_idle_w_valid", w_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64: beat width, matching the FIFO WIDTH.
REQ-003 The block SHALL have parameter BURST_MAX, default 4: maximum beats per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester beat valid.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's beat in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester beat accept.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: FIFO full flag.
REQ-010 The block SHALL have port w_valid, output, 1 bit: FIFO write strobe; a push occurs at an edge where w_valid=1 and fifo_full=0.
REQ-011 The block SHALL have port data_in, output, DATA_WIDTH bits: FIFO write data.
REQ-012 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: current or last granted requester.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 while state is GRANT or w_valid=1.
REQ-014 The block SHALL have port push_cnt, output, 16 bits: count of completed FIFO pushes, wrapping 0xFFFF->0.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-016 In IDLE with any req_valid bit set, the block SHALL pick round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap, load grant_id, clear beat_cnt, set last_grant to the pick, and enter GRANT next cycle.
REQ-017 In IDLE, all req_ready bits SHALL be 0; IDLE with no req_valid set SHALL stay IDLE.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal (!w_valid || !fifo_full) combinationally, and every other req_ready bit SHALL be 0.
REQ-019 A beat SHALL be accepted at an edge where req_valid[g] and req_ready[g] are both 1; data_in SHALL be loaded with the slice, w_valid set to 1, and beat_cnt incremented.
REQ-020 w_valid and data_in SHALL hold unchanged while w_valid=1 and fifo_full=1; no beat is dropped or duplicated.
REQ-021 At a push edge with no new accept, w_valid SHALL clear; with a new accept, w_valid SHALL remain 1 (back-to-back, one beat per cycle).
REQ-022 push_cnt SHALL increment by 1 at each push edge.
REQ-023 GRANT SHALL return to IDLE after the BURST_MAX-th accepted beat, or on any GRANT cycle where req_valid[grant_id]=0.
REQ-024 Each IDLE visit SHALL cost one arbitration cycle; the maximum sustained rate to a single requester is BURST_MAX beats per BURST_MAX+1 cycles.
REQ-025 Changes on non-granted req_valid bits during GRANT SHALL be ignored until the next IDLE.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, w_valid=0, data_in=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0, push_cnt=0, and busy=0, regardless of the clock.
REQ-027 Reset asserted mid-burst or with w_valid=1 SHALL discard the pending beat; the system SHALL reset the FIFO together with the block.

Structure
REQ-028 The FSM state enum SHALL reside in the shared package fifo_pkg.
REQ-029 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs: request vector and last grant; outputs: grant index and any).

Verification
REQ-030 Bench SHALL use NUM_REQ=4, BURST_MAX=4, and a real fifo of DEPTH 8 with a per-requester scoreboard.
REQ-031 Scenario: all 4 requesters hold valid with 8 beats each -> grant order 0,1,2,3,0,1,2,3, 4-beat bursts, push_cnt=32, per-source order preserved.
REQ-032 Scenario: requester 2 alone sends 3 beats then drops valid -> 3 pushes, GRANT->IDLE on the drop cycle, grant_id=2.
REQ-033 Scenario: FIFO full with no pops, requester 1 sends 10 beats -> exactly 8 pushes, w_valid held with 9th beat stable, req_ready[1]=0; after one pop, the 9th beat is pushed.
REQ-034 Scenario: rst_n pulsed low mid-burst with w_valid=1 -> outputs reach reset values immediately, the next grant goes to requester 0, push_cnt=0.
REQ-035 Scenario: 10000 cycles of random valid/pop -> the scoreboard matches every FIFO output, and no requester waits more than 3*(BURST_MAX+1) cycles after its valid while the FIFO is not full.
